videomem3: RTL and testbench
============================

Name: videomem3

Overview:
Parametrised successor character video memory for the VGA text path. It holds a CH_WIDTH_SCREEN x CH_HEIGHT_SCREEN character buffer and accepts a byte stream through a cursor-driven terminal write port (auto-advance, CR/LF/BS, line and screen wrap). A hardware clear engine fills the buffer. A registered 2-stage scan pipeline turns the current pixel coordinate into RGB through the internal fontrom, sitting between the sync generator and the DAC outputs.

Parameters:
DISP_WIDTH_PX, 640, visible width in pixels
DISP_HEIGHT_PX, 480, visible height in pixels
CH_WIDTH, 4, glyph width in px; fontrom glyph is CH_WIDTH*CH_HEIGHT bits
CH_HEIGHT, 8, glyph height in px
CH_WIDTH_SCREEN, DISP_WIDTH_PX/CH_WIDTH, columns (160)
CH_HEIGHT_SCREEN, DISP_HEIGHT_PX/CH_HEIGHT, rows (60)
CH_SCREENSIZE, CH_WIDTH_SCREEN*CH_HEIGHT_SCREEN, buffer depth (9600)
COLOR_W, 6, bits per colour channel
FG_COLOR, 18'h3FFFF, {r,g,b} for glyph-set pixels
BG_COLOR, 18'h00000, {r,g,b} for glyph-clear pixels
CLEAR_CHAR, 8'd32, fill code used by clear

Ports:
vm_clk  input  1  single clock; all logic on rising edge
vm_rst  input  1  synchronous reset, active-high
vm_px  input  10  pixel column being scanned
vm_py  input  10  pixel row being scanned
vm_ch_in  input  8  character/control code to write
vm_ch_write_enable  input  1  write strobe, one code per cycle
vm_clear  input  1  start a clear-screen pass
vm_busy  output  1  clear in progress; writes and clears ignored
vm_cursor_x  output  $clog2(CH_WIDTH_SCREEN)  current cursor column
vm_cursor_y  output  $clog2(CH_HEIGHT_SCREEN)  current cursor row
vm_r, vm_g, vm_b  output  COLOR_W each  pixel colour

Behaviour:
- Reset (vm_clk edge with vm_rst=1): cursor (0,0), vm_busy=0, clear counter 0, pipeline regs cleared, vm_r/g/b=0. Buffer contents are not reset; power-up contents are all CLEAR_CHAR.
- Reset mid-clear aborts immediately: busy=0, partially cleared buffer kept.
- Buffer address = row*CH_WIDTH_SCREEN + col, for both write and scan.
- Write accepted only when vm_ch_write_enable=1 and vm_busy=0. Otherwise the code is dropped.
- 8'd10 (LF): x=0, y=y+1.
- 8'd13 (CR): x=0, y unchanged.
- 8'd8 (BS): if x>0 then x=x-1, else no change. No buffer write.
- Any other code: buffer[y,x]=code. Then x=x+1; if x was CH_WIDTH_SCREEN-1, x=0 and y=y+1.
- y wraps from CH_HEIGHT_SCREEN-1 to 0 (no scroll).
- Cursor updates visible on the cycle after the accepting edge.
- Clear FSM states IDLE, CLEAR.
  - IDLE: vm_clear=1 and not busy -> CLEAR, counter=0, busy=1 next cycle.
  - CLEAR: writes CLEAR_CHAR to buffer[counter] each cycle, counter+1.
  - After writing CH_SCREENSIZE-1 -> IDLE, busy=0, cursor=(0,0).
  - busy stays high exactly CH_SCREENSIZE cycles.
- vm_clear and a write on the same edge in IDLE: clear wins, the write is dropped. vm_clear while busy is ignored.
- Scan pipeline, latency 2.
  - Stage 1 (edge N): register buffer read of address (py/CH_HEIGHT)*CH_WIDTH_SCREEN + px/CH_WIDTH, gx=px%CH_WIDTH, gy=py%CH_HEIGHT, vis=(px<DISP_WIDTH_PX && py<DISP_HEIGHT_PX).
  - Stage 2 (edge N+1): fontrom(char) combinational. Bit = glyph[(CH_HEIGHT-1-gy)*CH_WIDTH + (CH_WIDTH-1-gx)], so row 0 sits in the MSBs.
  - Outputs register FG_COLOR if bit=1, BG_COLOR if bit=0, or 0 if !vis.
  - Colour for (px,py) presented at edge N appears after edge N+1, i.e. 2 cycles.
- Buffer is simple dual-port (one write, one read port). Same-address read during write returns old data (read-first).
- Scan is never stalled by writes or clear.
- Division and modulo by powers of two reduce to shifts/slices. Non-power-of-two parameters must still synthesise correctly.

Test Plan:
- Reset -> vm_r/g/b=0, busy=0, cursor (0,0); after 2 scan cycles at (0,0), output = glyph(32) pixel colour.
- Write 8'd72, 8'd105 -> buffer[0]=72, buffer[1]=105, cursor (2,0); scan px=4..7, py=0..7 -> pixels match fontrom(105) with 2-cycle latency.
- Cursor at x=159,y=59, write 8'd65 -> buffer[9599]=65, cursor wraps to (0,0).
- From (5,3): LF -> (0,4); from (5,4): CR -> (0,4); BS at (0,4) -> (0,4); BS at (3,4) -> (2,4); buffer unchanged by control codes.
- vm_clear=1 with write on the same edge -> write dropped, busy high 9600 cycles, writes during busy ignored, all locations = 32, cursor (0,0) when busy falls.
- Reset at clear cycle 100 -> busy=0 next cycle, locations 0..99 = 32, rest retained.
- px=640 or py=480 -> output 0 two cycles later regardless of buffer contents.

Source files
------------

// File: rtl/videomem3.sv
// videomem3: character video memory for the VGA text path.
//
// Holds a CH_WIDTH_SCREEN x CH_HEIGHT_SCREEN byte buffer written through a
// cursor-driven terminal port (auto-advance, CR/LF/BS, line and screen wrap).
// It also has a clear engine that fills the buffer with CLEAR_CHAR, and a
// 2-stage scan pipeline that maps (vm_px, vm_py) to an RGB pixel through the
// internal font ROM.
//
// Ports:
//   vm_clk              clock, all logic on the rising edge
//   vm_rst              synchronous active-high reset
//   vm_px, vm_py        pixel coordinate being scanned
//   vm_ch_in            character/control code to write
//   vm_ch_write_enable  write strobe, one code per cycle
//   vm_clear            start a clear-screen pass
//   vm_busy             clear in progress; writes and clears are dropped
//   vm_cursor_x/y       current cursor column/row
//   vm_r, vm_g, vm_b    pixel colour, valid 2 cycles after vm_px/vm_py
//
// Font ROM: the space glyph (8'd32) is blank. For any other code, glyph row r
// uses the pattern p = code ^ 8'(r * 8'h35), and pixel column c is bit p[c % 8].
// The glyph is packed with row 0 in the MSBs and column 0 as the
// most-significant bit of its row.
module videomem3 #(
    parameter int unsigned DISP_WIDTH_PX    = 640,
    parameter int unsigned DISP_HEIGHT_PX   = 480,
    parameter int unsigned CH_WIDTH         = 4,
    parameter int unsigned CH_HEIGHT        = 8,
    parameter int unsigned CH_WIDTH_SCREEN  = DISP_WIDTH_PX / CH_WIDTH,
    parameter int unsigned CH_HEIGHT_SCREEN = DISP_HEIGHT_PX / CH_HEIGHT,
    parameter int unsigned CH_SCREENSIZE    = CH_WIDTH_SCREEN * CH_HEIGHT_SCREEN,
    parameter int unsigned COLOR_W          = 6,
    parameter logic [3*COLOR_W-1:0] FG_COLOR = 18'h3FFFF,
    parameter logic [3*COLOR_W-1:0] BG_COLOR = 18'h00000,
    parameter logic [7:0] CLEAR_CHAR        = 8'd32
) (
    input  logic                                vm_clk,
    input  logic                                vm_rst,
    input  logic [9:0]                          vm_px,
    input  logic [9:0]                          vm_py,
    input  logic [7:0]                          vm_ch_in,
    input  logic                                vm_ch_write_enable,
    input  logic                                vm_clear,
    output logic                                vm_busy,
    output logic [$clog2(CH_WIDTH_SCREEN)-1:0]  vm_cursor_x,
    output logic [$clog2(CH_HEIGHT_SCREEN)-1:0] vm_cursor_y,
    output logic [COLOR_W-1:0]                  vm_r,
    output logic [COLOR_W-1:0]                  vm_g,
    output logic [COLOR_W-1:0]                  vm_b
);

    localparam int unsigned AW         = $clog2(CH_SCREENSIZE);
    localparam int unsigned XW         = $clog2(CH_WIDTH_SCREEN);
    localparam int unsigned YW         = $clog2(CH_HEIGHT_SCREEN);
    localparam int unsigned GXW        = (CH_WIDTH > 1) ? $clog2(CH_WIDTH) : 1;
    localparam int unsigned GYW        = (CH_HEIGHT > 1) ? $clog2(CH_HEIGHT) : 1;
    localparam int unsigned GLYPH_BITS = CH_WIDTH * CH_HEIGHT;
    localparam int unsigned RGB_W      = 3 * COLOR_W;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    function automatic logic [GLYPH_BITS-1:0] fontrom(input logic [7:0] code);
        logic [GLYPH_BITS-1:0] g;
        logic [7:0]            pat;
        g = '0;
        if (code != 8'd32) begin
            for (int r = 0; r < int'(CH_HEIGHT); r++) begin
                pat = code ^ 8'(r * 8'h35);
                for (int c = 0; c < int'(CH_WIDTH); c++) begin
                    g[(int'(CH_HEIGHT) - 1 - r) * int'(CH_WIDTH) + (int'(CH_WIDTH) - 1 - c)] =
                        pat[3'(c % 8)];
                end
            end
        end
        return g;
    endfunction

    // Power-up contents are all CLEAR_CHAR; the buffer itself is never reset.
    logic [7:0] mem [CH_SCREENSIZE] = '{default: CLEAR_CHAR};

    state_e          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic [XW-1:0]   cx_q;
    logic [YW-1:0]   cy_q;
    logic [YW-1:0]   cy_next;

    logic            is_ctrl;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [7:0]      wr_data;

    logic [31:0]     col_c, row_c;
    logic            vis_c;
    logic [AW-1:0]   scan_addr;
    logic [GXW-1:0]  gx_c;
    logic [GYW-1:0]  gy_c;

    logic [7:0]      ch_q;
    logic [GXW-1:0]  gx_q;
    logic [GYW-1:0]  gy_q;
    logic            vis_q;
    logic [RGB_W-1:0] rgb_q;

    logic [GLYPH_BITS-1:0] glyph_c;
    int unsigned     bit_idx;

    assign vm_busy     = (state_q == StClear);
    assign vm_cursor_x = cx_q;
    assign vm_cursor_y = cy_q;
    assign vm_r        = rgb_q[RGB_W-1:2*COLOR_W];
    assign vm_g        = rgb_q[2*COLOR_W-1:COLOR_W];
    assign vm_b        = rgb_q[COLOR_W-1:0];

    assign is_ctrl = (vm_ch_in == 8'd10) || (vm_ch_in == 8'd13) || (vm_ch_in == 8'd8);
    assign cy_next = (cy_q == YW'(CH_HEIGHT_SCREEN - 1)) ? '0 : cy_q + 1'b1;

    // Single write port shared by the clear engine and the terminal port.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (!vm_rst) begin
            if (state_q == StClear) begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt_q;
                wr_data = CLEAR_CHAR;
            end else if (vm_ch_write_enable && !vm_clear && !is_ctrl) begin
                wr_en   = 1'b1;
                wr_addr = AW'(32'(cy_q) * CH_WIDTH_SCREEN + 32'(cx_q));
                wr_data = vm_ch_in;
            end
        end
    end

    // Clear FSM and cursor.
    always_ff @(posedge vm_clk) begin
        if (vm_rst) begin
            state_q   <= StIdle;
            clr_cnt_q <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (vm_clear) begin
                        state_q   <= StClear;
                        clr_cnt_q <= '0;
                    end else if (vm_ch_write_enable) begin
                        unique case (vm_ch_in)
                            8'd10: begin
                                cx_q <= '0;
                                cy_q <= cy_next;
                            end
                            8'd13: cx_q <= '0;
                            8'd8: if (cx_q != '0) cx_q <= cx_q - 1'b1;
                            default: begin
                                if (cx_q == XW'(CH_WIDTH_SCREEN - 1)) begin
                                    cx_q <= '0;
                                    cy_q <= cy_next;
                                end else begin
                                    cx_q <= cx_q + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                StClear: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == AW'(CH_SCREENSIZE - 1)) begin
                        state_q <= StIdle;
                        cx_q    <= '0;
                        cy_q    <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stage 1 address/offset decode; non-power-of-two sizes still divide correctly.
    always_comb begin
        col_c     = 32'(vm_px) / CH_WIDTH;
        row_c     = 32'(vm_py) / CH_HEIGHT;
        vis_c     = (32'(vm_px) < DISP_WIDTH_PX) && (32'(vm_py) < DISP_HEIGHT_PX);
        scan_addr = vis_c ? AW'(row_c * CH_WIDTH_SCREEN + col_c) : '0;
        gx_c      = GXW'(32'(vm_px) % CH_WIDTH);
        gy_c      = GYW'(32'(vm_py) % CH_HEIGHT);
    end

    // Simple dual-port RAM, read-first. ch_q is not reset: vis_q masks it.
    always_ff @(posedge vm_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        ch_q <= mem[scan_addr];
    end

    always_ff @(posedge vm_clk) begin
        if (vm_rst) begin
            gx_q  <= '0;
            gy_q  <= '0;
            vis_q <= 1'b0;
        end else begin
            gx_q  <= gx_c;
            gy_q  <= gy_c;
            vis_q <= vis_c;
        end
    end

    // Stage 2: glyph lookup and colour select.
    always_comb begin
        glyph_c = fontrom(ch_q);
        bit_idx = (CH_HEIGHT - 1 - 32'(gy_q)) * CH_WIDTH + (CH_WIDTH - 1 - 32'(gx_q));
    end

    always_ff @(posedge vm_clk) begin
        if (vm_rst) begin
            rgb_q <= '0;
        end else if (!vis_q) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= glyph_c[bit_idx] ? FG_COLOR : BG_COLOR;
        end
    end

endmodule

// File: tb/tb_videomem3.sv
module tb_videomem3;

    localparam logic [17:0] FG = 18'h3FFFF;
    localparam logic [17:0] BG = 18'h00000;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] px, py;
    logic [7:0] ch;
    logic       we, clr;
    logic       busy;
    logic [7:0] cx;
    logic [5:0] cy;
    logic [5:0] r, g, b;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    videomem3 dut (
        .vm_clk             (clk),
        .vm_rst             (rst),
        .vm_px              (px),
        .vm_py              (py),
        .vm_ch_in           (ch),
        .vm_ch_write_enable (we),
        .vm_clear           (clr),
        .vm_busy            (busy),
        .vm_cursor_x        (cx),
        .vm_cursor_y        (cy),
        .vm_r               (r),
        .vm_g               (g),
        .vm_b               (b)
    );

    // Reference model: screen as a flat array, cursor as plain integers.
    logic [7:0]  mm [9600] = '{default: 8'd32};
    int          mx = 0, my = 0;
    logic        mbusy = 1'b0;
    int          mcnt = 0;
    logic [17:0] ms1 = '0, mout = '0;

    function automatic logic [17:0] model_colour(input int x, input int y, input logic [7:0] code);
        logic [7:0] pat;
        if (x >= 640 || y >= 480) return 18'h0;
        if (code == 8'd32) return BG;
        pat = code ^ 8'((y % 8) * 53);
        return pat[x % 4] ? FG : BG;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
            mx    <= 0;
            my    <= 0;
            ms1   <= '0;
            mout  <= '0;
        end else begin
            ms1  <= model_colour(int'(px), int'(py),
                                 (px < 640 && py < 480) ? mm[(py / 8) * 160 + px / 4] : 8'd0);
            mout <= ms1;
            if (mbusy) begin
                mm[mcnt] <= 8'd32;
                mcnt     <= mcnt + 1;
                if (mcnt == 9599) begin
                    mbusy <= 1'b0;
                    mx    <= 0;
                    my    <= 0;
                end
            end else if (clr) begin
                mbusy <= 1'b1;
                mcnt  <= 0;
            end else if (we) begin
                if (ch == 8'd10) begin
                    mx <= 0;
                    my <= (my + 1) % 60;
                end else if (ch == 8'd13) begin
                    mx <= 0;
                end else if (ch == 8'd8) begin
                    if (mx > 0) mx <= mx - 1;
                end else begin
                    mm[my * 160 + mx] <= ch;
                    if (mx == 159) begin
                        mx <= 0;
                        my <= (my + 1) % 60;
                    end else begin
                        mx <= mx + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", 32'(busy), 32'(mbusy));
            chk("cursor_x", 32'(cx), mx);
            chk("cursor_y", 32'(cy), my);
            chk("rgb", 32'({r, g, b}), 32'(mout));
        end
    end

    task automatic put(input logic [7:0] code);
        ch = code;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic scan_lit(input int x, input int y, input logic [17:0] exp, input string name);
        px = 10'(x);
        py = 10'(y);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(name, 32'({r, g, b}), 32'(exp));
    endtask

    task automatic scan_all();
        for (int i = 0; i < 9600; i++) begin
            px = 10'((i % 160) * 4);
            py = 10'((i / 160) * 8);
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) put(8'(65 + 2 * (i % 10)));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        px  = '0;
        py  = '0;
        ch  = '0;
        we  = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_rgb", 32'({r, g, b}), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_cx", 32'(cx), 32'h0);
        chk("reset_cy", 32'(cy), 32'h0);
        scan_lit(0, 0, BG, "space_glyph");

        put(8'd72);
        put(8'd105);
        chk("hi_cx", 32'(cx), 32'd2);
        chk("hi_cy", 32'(cy), 32'd0);
        for (int y = 0; y < 8; y++) begin
            for (int x = 4; x < 8; x++) begin
                px = 10'(x);
                py = 10'(y);
                @(posedge clk);
                #1;
            end
        end
        // 105 = 8'h69: row 0 pattern 0x69, row 1 pattern 0x5C.
        scan_lit(4, 0, FG, "i_px4_py0");
        scan_lit(5, 0, BG, "i_px5_py0");
        scan_lit(6, 1, FG, "i_px6_py1");
        // 72 = 8'h48.
        scan_lit(0, 0, BG, "h_px0_py0");
        scan_lit(3, 0, FG, "h_px3_py0");
        scan_lit(640, 0, 18'h0, "px640_blank");
        scan_lit(4, 480, 18'h0, "py480_blank");

        // Fill to the last cell, then wrap.
        put(8'd13);
        fill(9599);
        chk("end_cx", 32'(cx), 32'd159);
        chk("end_cy", 32'(cy), 32'd59);
        put(8'd65);
        chk("wrap_cx", 32'(cx), 32'd0);
        chk("wrap_cy", 32'(cy), 32'd0);
        scan_lit(636, 472, FG, "last_cell_65");

        // Control codes.
        repeat (3) put(8'd10);
        repeat (5) put(8'd67);
        put(8'd10);
        chk("lf_cx", 32'(cx), 32'd0);
        chk("lf_cy", 32'(cy), 32'd4);
        repeat (5) put(8'd69);
        put(8'd13);
        chk("cr_cx", 32'(cx), 32'd0);
        chk("cr_cy", 32'(cy), 32'd4);
        put(8'd8);
        chk("bs0_cx", 32'(cx), 32'd0);
        repeat (3) put(8'd71);
        put(8'd8);
        chk("bs3_cx", 32'(cx), 32'd2);
        chk("bs3_cy", 32'(cy), 32'd4);
        for (int c = 0; c < 6; c++) begin
            for (int y = 0; y < 8; y++) begin
                for (int x = 0; x < 4; x++) begin
                    px = 10'(c * 4 + x);
                    py = 10'(32 + y);
                    @(posedge clk);
                    #1;
                end
            end
        end

        // Clear with a simultaneous write; writes and clears during busy are dropped.
        clr = 1'b1;
        we  = 1'b1;
        ch  = 8'd77;
        @(posedge clk);
        #1;
        clr = 1'b0;
        ch  = 8'd79;
        chk("clear_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 20000) begin
            n++;
            we  = (n < 50);
            clr = (n == 10);
            @(posedge clk);
            #1;
        end
        we  = 1'b0;
        clr = 1'b0;
        chk("busy_len", n, 32'd9600);
        chk("clear_cx", 32'(cx), 32'd0);
        chk("clear_cy", 32'(cy), 32'd0);
        scan_all();

        // Refill, then reset 100 cycles into a clear.
        fill(9600);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        scan_lit(396, 0, BG, "cell99_cleared");
        scan_lit(400, 0, FG, "cell100_kept");
        scan_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
